// File: rtl/aes_dec_round_seq.sv
// Round sequencer for inv_round_tf: initial AddRoundKey, NR driven rounds, plaintext out.
// Optional watchdog on the round handshake when DEC_TIMEOUT_EN is defined.
module aes_dec_round_seq #(
  parameter int NR      = 10,
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [127:0] ct_i,
  output logic         busy_o,
  output logic [3:0]   rk_idx_o,
  input  logic [127:0] rk_i,
  output logic         rnd_start_o,
  output logic [127:0] rnd_b_o,
  output logic         rnd_bypass_mc_o,
  input  logic [127:0] rnd_b_i,
  input  logic         rnd_done_i,
  output logic [127:0] pt_o,
  output logic         done_o,
  output logic         err_o
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_FIN} fsm_t;

  fsm_t         r_fsm;
  logic [127:0] r_state;
  logic [3:0]   r_rk_idx;
  logic         r_busy;
  logic         r_rnd_start;
  logic         r_bypass;
  logic         r_done;
`ifdef DEC_TIMEOUT_EN
  logic [7:0]   r_wdog;
  logic         r_err;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm       <= S_IDLE;
      r_state     <= '0;
      r_rk_idx    <= '0;
      r_busy      <= 1'b0;
      r_rnd_start <= 1'b0;
      r_bypass    <= 1'b0;
      r_done      <= 1'b0;
`ifdef DEC_TIMEOUT_EN
      r_wdog      <= '0;
      r_err       <= 1'b0;
`endif
    end else begin
      r_rnd_start <= 1'b0;
      r_done      <= 1'b0;
`ifdef DEC_TIMEOUT_EN
      r_err       <= 1'b0;
`endif
      case (r_fsm)
        S_IDLE: begin
          if (start_i) begin
            r_state  <= ct_i;
            r_rk_idx <= 4'(NR);
            r_busy   <= 1'b1;
            r_fsm    <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_state     <= r_state ^ rk_i;
          r_rk_idx    <= 4'(NR - 1);
          r_rnd_start <= 1'b1;
          r_bypass    <= (4'(NR - 1) == 4'd0);
          r_fsm       <= S_ISSUE;
        end
        S_ISSUE: begin
          // done in the issue cycle is not looked at: the round unit needs L>=1
          r_fsm <= S_WAIT;
`ifdef DEC_TIMEOUT_EN
          r_wdog <= '0;
`endif
        end
        S_WAIT: begin
          if (rnd_done_i) begin
            r_state <= rnd_b_i ^ rk_i;
            if (r_rk_idx == 4'd0) begin
              r_bypass <= 1'b0;
              r_done   <= 1'b1;
              r_fsm    <= S_FIN;
            end else begin
              r_rk_idx    <= r_rk_idx - 4'd1;
              r_rnd_start <= 1'b1;
              r_bypass    <= (r_rk_idx == 4'd1);
              r_fsm       <= S_ISSUE;
            end
          end
`ifdef DEC_TIMEOUT_EN
          else if (r_wdog == 8'(TIMEOUT - 1)) begin
            // abandon the operation; the partial state must not reach pt_o
            r_state  <= '0;
            r_rk_idx <= '0;
            r_bypass <= 1'b0;
            r_busy   <= 1'b0;
            r_err    <= 1'b1;
            r_fsm    <= S_IDLE;
          end else begin
            r_wdog <= r_wdog + 8'd1;
          end
`endif
        end
        S_FIN: begin
          r_busy <= 1'b0;
          r_fsm  <= S_IDLE;
        end
        default: r_fsm <= S_IDLE;
      endcase
    end
  end

  assign busy_o          = r_busy;
  assign rk_idx_o        = r_rk_idx;
  assign rnd_start_o     = r_rnd_start;
  assign rnd_bypass_mc_o = r_bypass;
  assign rnd_b_o         = r_state;
  assign pt_o            = r_state;
  assign done_o          = r_done;
`ifdef DEC_TIMEOUT_EN
  assign err_o = r_err;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^32'(TIMEOUT);
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_aes_dec_round_seq.sv
// Bench for aes_dec_round_seq: AES key-store and inv_round_tf (L=3) models, FIPS-197 vector.
module tb_aes_dec_round_seq;

  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam int LAT_EXP = 42;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_i;
  logic [127:0] ct_i;
  logic         busy_o;
  logic [3:0]   rk_idx_o;
  logic [127:0] rk_i;
  logic         rnd_start_o;
  logic [127:0] rnd_b_o;
  logic         rnd_bypass_mc_o;
  logic [127:0] rnd_b_i;
  logic         rnd_done_i;
  logic [127:0] pt_o;
  logic         done_o;
  logic         err_o;

  int n_checks = 0;
  int n_errors = 0;

  aes_dec_round_seq #(.NR(10), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .ct_i(ct_i), .busy_o(busy_o),
    .rk_idx_o(rk_idx_o), .rk_i(rk_i), .rnd_start_o(rnd_start_o), .rnd_b_o(rnd_b_o),
    .rnd_bypass_mc_o(rnd_bypass_mc_o), .rnd_b_i(rnd_b_i), .rnd_done_i(rnd_done_i),
    .pt_o(pt_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  // ---------------- AES reference arithmetic ----------------
  logic [7:0]   sbox  [256];
  logic [7:0]   isbox [256];
  logic [127:0] dk    [16];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p = 8'h00; aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
    return (a << n) | (a >> (8 - n));
  endfunction

  function automatic logic [7:0] sb_calc(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] x);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = x[127-32*c -: 8]; a1 = x[119-32*c -: 8];
      a2 = x[111-32*c -: 8]; a3 = x[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0,8'd14) ^ gmul(a1,8'd11) ^ gmul(a2,8'd13) ^ gmul(a3,8'd9);
      o[119-32*c -: 8] = gmul(a0,8'd9)  ^ gmul(a1,8'd14) ^ gmul(a2,8'd11) ^ gmul(a3,8'd13);
      o[111-32*c -: 8] = gmul(a0,8'd13) ^ gmul(a1,8'd9)  ^ gmul(a2,8'd14) ^ gmul(a3,8'd11);
      o[103-32*c -: 8] = gmul(a0,8'd11) ^ gmul(a1,8'd13) ^ gmul(a2,8'd9)  ^ gmul(a3,8'd14);
    end
    return o;
  endfunction

  // InvShiftRows + InvSubBytes, then InvMixColumns unless bypassed
  function automatic logic [127:0] inv_round(input logic [127:0] b, input logic byp);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) s[i] = b[127-8*i -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[((c + r) % 4) * 4 + r] = isbox[s[c*4 + r]];
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
    return byp ? o : inv_mix(o);
  endfunction

  task automatic build_tables();
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    for (int x = 0; x < 256; x++) sbox[x] = sb_calc(8'(x));
    for (int x = 0; x < 256; x++) isbox[sbox[x]] = 8'(x);
    for (int i = 0; i < 4; i++) w[i] = KEY[127-32*i -: 32];
    rcon = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++) dk[r] = '0;
    for (int r = 0; r <= 10; r++) begin
      dk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      if (r >= 1 && r <= 9) dk[r] = inv_mix(dk[r]);
    end
  endtask

  // Key store (combinational) and round-unit model (L=3)
  assign rk_i = dk[rk_idx_o];

  logic [1:0] m_cnt;
  logic       m_done;
  logic       spur_done;
  logic       mute;
  assign rnd_done_i = (m_done & ~mute) | spur_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= 2'd0; m_done <= 1'b0; rnd_b_i <= '0;
    end else begin
      m_done <= 1'b0;
      if (rnd_start_o) begin
        m_cnt   <= 2'd1;
        rnd_b_i <= inv_round(rnd_b_o, rnd_bypass_mc_o);
      end else if (m_cnt == 2'd2) begin
        m_cnt  <= 2'd0;
        m_done <= 1'b1;
      end else if (m_cnt != 2'd0) begin
        m_cnt <= m_cnt + 2'd1;
      end
    end
  end

  // Drives one start and observes until done_o; cycle 1 is the first cycle after the sampling edge.
  task automatic run_op(input logic [127:0] ct, input bit keep, input bit spur_issue,
                        output int cycles, output int starts,
                        output bit seq_ok, output bit byp_ok, output bit busy_ok);
    bit got;
    @(negedge clk); start_i = 1'b1; ct_i = ct;
    @(posedge clk);
    cycles = 0; starts = 0; seq_ok = 1; byp_ok = 1; busy_ok = 1; got = 0;
    for (int n = 1; n <= 500 && !got; n++) begin
      @(negedge clk);
      if (!keep) start_i = 1'b0;
      spur_done = spur_issue && rnd_start_o;
      if (n == 1 && rk_idx_o !== 4'd10) seq_ok = 0;
      if (rnd_start_o === 1'b1) begin
        starts++;
        if (rk_idx_o !== 4'(10 - starts)) seq_ok = 0;
        if (rnd_bypass_mc_o !== (starts == 10)) byp_ok = 0;
      end else if (rnd_bypass_mc_o === 1'b1 && starts != 10) byp_ok = 0;
      if (busy_o !== 1'b1) busy_ok = 0;
      if (done_o === 1'b1) begin got = 1; cycles = n; end
    end
    spur_done = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy_o, rnd_start_o, rnd_bypass_mc_o, done_o, err_o} !== 5'b0) begin
      n_errors++; $display("FAIL reset_ctrl: got %b want 00000", {busy_o, rnd_start_o, rnd_bypass_mc_o, done_o, err_o});
    end
    n_checks++;
    if (rk_idx_o !== 4'd0 || pt_o !== 128'h0 || rnd_b_o !== 128'h0) begin
      n_errors++; $display("FAIL reset_data: rk_idx=%0d pt=%h want 0", rk_idx_o, pt_o);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fips();
    int cyc, st; bit sq, bp, bz;
    run_op(CT, 0, 0, cyc, st, sq, bp, bz);
    n_checks++;
    if (pt_o !== PT) begin n_errors++; $display("FAIL fips_pt: got %h want %h", pt_o, PT); end
    n_checks++;
    if (cyc != LAT_EXP) begin n_errors++; $display("FAIL fips_latency: got %0d want %0d", cyc, LAT_EXP); end
    n_checks++;
    if (st != 10) begin n_errors++; $display("FAIL fips_starts: got %0d want 10", st); end
    n_checks++;
    if (!sq) begin n_errors++; $display("FAIL fips_rk_seq: got out-of-order index want 10..0"); end
    n_checks++;
    if (!bp) begin n_errors++; $display("FAIL fips_bypass: got bypass outside last round want last only"); end
    n_checks++;
    if (!bz) begin n_errors++; $display("FAIL fips_busy: got busy low during op want high"); end
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || rk_idx_o !== 4'd0 || pt_o !== PT) begin
      n_errors++; $display("FAIL fips_idle_hold: busy=%b done=%b rk=%0d pt=%h want 0,0,0,%h",
                           busy_o, done_o, rk_idx_o, pt_o, PT);
    end
  endtask

  task automatic test_back_to_back();
    int cyc, st; bit sq, bp, bz, got;
    run_op(CT, 1, 0, cyc, st, sq, bp, bz);
    n_checks++;
    if (pt_o !== PT || st != 10 || cyc != LAT_EXP) begin
      n_errors++; $display("FAIL b2b_first: pt=%h starts=%0d lat=%0d want %h,10,%0d", pt_o, st, cyc, PT, LAT_EXP);
    end
    @(negedge clk);
    n_checks++;
    if (busy_o !== 1'b0) begin n_errors++; $display("FAIL b2b_idle_gap: got busy=%b want 0", busy_o); end
    @(negedge clk);
    n_checks++;
    if (busy_o !== 1'b1) begin n_errors++; $display("FAIL b2b_restart: got busy=%b want 1", busy_o); end
    got = 0;
    for (int n = 0; n < 500 && !got; n++) begin
      @(negedge clk);
      if (done_o === 1'b1) got = 1;
    end
    start_i = 1'b0;
    n_checks++;
    if (!got || pt_o !== PT) begin n_errors++; $display("FAIL b2b_second: done=%b pt=%h want 1,%h", got, pt_o, PT); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int st, cyc; bit sq, bp, bz;
    @(negedge clk); start_i = 1'b1; ct_i = CT;
    @(negedge clk); start_i = 1'b0;
    st = 0;
    for (int n = 0; n < 400 && st < 5; n++) begin
      @(negedge clk);
      if (rnd_start_o === 1'b1) st++;
    end
    @(negedge clk);
    n_checks++;
    if (st != 5 || busy_o !== 1'b1) begin n_errors++; $display("FAIL rstmid_reach: got starts=%0d want 5", st); end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy_o, rnd_start_o, rnd_bypass_mc_o, done_o, err_o} !== 5'b0 || rk_idx_o !== 4'd0 ||
        pt_o !== 128'h0 || rnd_b_o !== 128'h0) begin
      n_errors++; $display("FAIL rstmid_outputs: busy=%b rk=%0d pt=%h want all 0", busy_o, rk_idx_o, pt_o);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    run_op(CT, 0, 0, cyc, st, sq, bp, bz);
    n_checks++;
    if (pt_o !== PT || cyc != LAT_EXP) begin
      n_errors++; $display("FAIL rstmid_fresh: pt=%h lat=%0d want %h,%0d", pt_o, cyc, PT, LAT_EXP);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_spurious_done();
    int cyc, st; bit sq, bp, bz;
    @(negedge clk); spur_done = 1'b1;
    @(negedge clk); spur_done = 1'b0;
    n_checks++;
    if (busy_o !== 1'b0 || pt_o !== PT) begin
      n_errors++; $display("FAIL spur_idle: busy=%b pt=%h want 0,%h", busy_o, pt_o, PT);
    end
    run_op(CT, 0, 1, cyc, st, sq, bp, bz);
    n_checks++;
    if (pt_o !== PT || cyc != LAT_EXP || st != 10) begin
      n_errors++; $display("FAIL spur_issue: pt=%h lat=%0d starts=%0d want %h,%0d,10", pt_o, cyc, st, PT, LAT_EXP);
    end
    repeat (2) @(negedge clk);
  endtask

`ifdef DEC_TIMEOUT_EN
  task automatic test_timeout();
    int k; bit seen_done, issued;
    mute = 1'b1; seen_done = 0; issued = 0;
    @(negedge clk); start_i = 1'b1; ct_i = CT;
    @(negedge clk); start_i = 1'b0;
    for (int n = 0; n < 20 && !issued; n++) begin
      @(negedge clk);
      if (rnd_start_o === 1'b1) issued = 1;
    end
    @(posedge clk);
    k = 0;
    for (int n = 1; n <= 40 && k == 0; n++) begin
      @(posedge clk); #1;
      if (done_o === 1'b1) seen_done = 1;
      if (err_o === 1'b1) k = n;
    end
    n_checks++;
    if (k != 16) begin n_errors++; $display("FAIL timeout_latency: got %0d want 16", k); end
    n_checks++;
    if (busy_o !== 1'b0 || seen_done || pt_o !== 128'h0) begin
      n_errors++; $display("FAIL timeout_state: busy=%b done_seen=%b pt=%h want 0,0,0", busy_o, seen_done, pt_o);
    end
    @(negedge clk);
    n_checks++;
    if (err_o !== 1'b0) begin n_errors++; $display("FAIL timeout_pulse: got err=%b want 0", err_o); end
    mute = 1'b0;
    repeat (5) @(negedge clk);
  endtask
`endif

  initial begin
    rst_n = 1'b0; start_i = 1'b0; ct_i = '0; spur_done = 1'b0; mute = 1'b0;
    build_tables();
    test_reset();
    test_fips();
    test_back_to_back();
    test_reset_mid();
    test_spurious_done();
`ifdef DEC_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
